riscv_alu_arbiter: RTL

Shares one `riscv_alu` instance among `NUM_REQ` requesters, for example the execute stage plus an address-generation or debug port. It accepts one operation at a time through a valid/ready handshake and picks among requesters round-robin. The ALU evaluates registered operands, and the block returns the registered `alu_out`/`br_flag` to the granted requester through a response handshake. It sits between the core's issue logic and the ALU datapath.

---
 rtl/riscv_alu_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/riscv_alu_arbiter.sv
// Round-robin arbiter that time-shares one RISC-V ALU among NUM_REQ requesters.
// One operation in flight at a time: IDLE (grant) -> EXEC (evaluate) -> RESP (return).

module riscv_alu #(
    parameter int WORD_LENGTH = 32,
    parameter int EXEC_FUN    = 5
) (
    input  logic [EXEC_FUN-1:0]    fun,
    input  logic [WORD_LENGTH-1:0] data1,
    input  logic [WORD_LENGTH-1:0] data2,
    output logic [WORD_LENGTH-1:0] alu_out,
    output logic                   br_flag
);
    localparam int SHAMT_W = $clog2(WORD_LENGTH);

    localparam logic [EXEC_FUN-1:0] FUN_ADD  = EXEC_FUN'(0);
    localparam logic [EXEC_FUN-1:0] FUN_SUB  = EXEC_FUN'(1);
    localparam logic [EXEC_FUN-1:0] FUN_SLL  = EXEC_FUN'(2);
    localparam logic [EXEC_FUN-1:0] FUN_SLT  = EXEC_FUN'(3);
    localparam logic [EXEC_FUN-1:0] FUN_SLTU = EXEC_FUN'(4);
    localparam logic [EXEC_FUN-1:0] FUN_XOR  = EXEC_FUN'(5);
    localparam logic [EXEC_FUN-1:0] FUN_SRL  = EXEC_FUN'(6);
    localparam logic [EXEC_FUN-1:0] FUN_SRA  = EXEC_FUN'(7);
    localparam logic [EXEC_FUN-1:0] FUN_OR   = EXEC_FUN'(8);
    localparam logic [EXEC_FUN-1:0] FUN_AND  = EXEC_FUN'(9);
    localparam logic [EXEC_FUN-1:0] FUN_JALR = EXEC_FUN'(10);
    localparam logic [EXEC_FUN-1:0] FUN_BEQ  = EXEC_FUN'(11);
    localparam logic [EXEC_FUN-1:0] FUN_BNE  = EXEC_FUN'(12);
    localparam logic [EXEC_FUN-1:0] FUN_BLT  = EXEC_FUN'(13);
    localparam logic [EXEC_FUN-1:0] FUN_BGE  = EXEC_FUN'(14);
    localparam logic [EXEC_FUN-1:0] FUN_BLTU = EXEC_FUN'(15);
    localparam logic [EXEC_FUN-1:0] FUN_BGEU = EXEC_FUN'(16);

    logic signed [WORD_LENGTH-1:0] sdata1;
    logic signed [WORD_LENGTH-1:0] sdata2;
    logic        [SHAMT_W-1:0]     shamt;
    logic        [WORD_LENGTH-1:0] sum;

    assign sdata1 = data1;
    assign sdata2 = data2;
    assign shamt  = data2[SHAMT_W-1:0];
    assign sum    = data1 + data2;

    always_comb begin
        alu_out = '0;
        br_flag = 1'b0;
        case (fun)
            FUN_ADD:  alu_out = sum;
            FUN_SUB:  alu_out = data1 - data2;
            FUN_SLL:  alu_out = data1 << shamt;
            FUN_SLT:  alu_out = WORD_LENGTH'(sdata1 < sdata2);
            FUN_SLTU: alu_out = WORD_LENGTH'(data1 < data2);
            FUN_XOR:  alu_out = data1 ^ data2;
            FUN_SRL:  alu_out = data1 >> shamt;
            FUN_SRA:  alu_out = $unsigned(sdata1 >>> shamt);
            FUN_OR:   alu_out = data1 | data2;
            FUN_AND:  alu_out = data1 & data2;
            FUN_JALR: alu_out = {sum[WORD_LENGTH-1:1], 1'b0};
            FUN_BEQ:  br_flag = (data1 == data2);
            FUN_BNE:  br_flag = (data1 != data2);
            FUN_BLT:  br_flag = (sdata1 < sdata2);
            FUN_BGE:  br_flag = (sdata1 >= sdata2);
            FUN_BLTU: br_flag = (data1 < data2);
            FUN_BGEU: br_flag = (data1 >= data2);
            default:  ;
        endcase
    end
endmodule

module riscv_alu_arbiter #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_REQ     = 2,
    parameter int EXEC_FUN    = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][EXEC_FUN-1:0]    req_fun,
    input  logic [NUM_REQ-1:0][WORD_LENGTH-1:0] req_data1,
    input  logic [NUM_REQ-1:0][WORD_LENGTH-1:0] req_data2,
    output logic [NUM_REQ-1:0]                  resp_valid,
    input  logic [NUM_REQ-1:0]                  resp_ready,
    output logic [WORD_LENGTH-1:0]              resp_alu_out,
    output logic                                resp_br_flag,
    output logic                                busy
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       rr_ptr_nxt;
    logic [PTR_W-1:0]       owner;
    logic [PTR_W-1:0]       owner_nxt;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W:0]         cand;
    logic                   grant_found;
    logic                   accept;

    logic [EXEC_FUN-1:0]    fun_p0;
    logic [WORD_LENGTH-1:0] data1_p0;
    logic [WORD_LENGTH-1:0] data2_p0;
    logic [WORD_LENGTH-1:0] alu_out;
    logic                   br_flag;

    // Rotating priority search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        req_ready  = '0;
        resp_valid = '0;
        accept     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (!flush && grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    owner_nxt            = grant_idx;
                    rr_ptr_nxt           = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                    state_nxt            = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt  = IDLE;
            resp_valid = '0;
        end
        // Reset masks all handshakes, even mid-operation; the op is dropped.
        if (rst) begin
            req_ready  = '0;
            resp_valid = '0;
            accept     = 1'b0;
            busy       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    // Stage p0: operand capture on the request handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            fun_p0   <= '0;
            data1_p0 <= '0;
            data2_p0 <= '0;
        end else if (accept) begin
            fun_p0   <= req_fun[grant_idx];
            data1_p0 <= req_data1[grant_idx];
            data2_p0 <= req_data2[grant_idx];
        end
    end

    riscv_alu #(
        .WORD_LENGTH (WORD_LENGTH),
        .EXEC_FUN    (EXEC_FUN)
    ) u_alu (
        .fun     (fun_p0),
        .data1   (data1_p0),
        .data2   (data2_p0),
        .alu_out (alu_out),
        .br_flag (br_flag)
    );

    // Stage p1: result capture at the end of EXEC, held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_alu_out <= '0;
            resp_br_flag <= 1'b0;
        end else if (state == EXEC && !flush) begin
            resp_alu_out <= alu_out;
            resp_br_flag <= br_flag;
        end
    end
endmodule
